// File: rtl/bsg_clk_gen_calib_pkg.sv
// Shared types and defaults for the oscillator calibration sequencer.
package bsg_clk_gen_calib_pkg;

    localparam int unsigned default_count_width_lp  = 16;
    localparam int unsigned default_window_width_lp = 20;

    typedef enum logic [2:0] {
        e_calib_idle,
        e_calib_mrst,
        e_calib_apply,
        e_calib_measure,
        e_calib_decide,
        e_calib_final,
        e_calib_final_measure,
        e_calib_done
    } bsg_clk_gen_calib_state_e;

    typedef enum logic [2:0] {
        e_meas_idle,
        e_meas_clear,
        e_meas_count,
        e_meas_hold,
        e_meas_sample
    } bsg_clk_gen_calib_meas_state_e;

endpackage

// File: rtl/bsg_clk_gen_calib_measure.sv
// One measurement pass: clear the divided-clock counter, count for a window,
// let it go quiescent, then take a sample that is stable on two consecutive cycles.
module bsg_clk_gen_calib_measure
    import bsg_clk_gen_calib_pkg::*;
#(
    parameter int unsigned count_width_p   = default_count_width_lp,
    parameter int unsigned window_width_p  = default_window_width_lp,
    parameter int unsigned settle_cycles_p = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic [count_width_p-1:0]  div_count_i,
    output logic                      div_clear_o,
    output logic                      div_enable_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  sample_o
);

    localparam int unsigned settle_width_lp = $clog2(settle_cycles_p + 1);
    localparam logic [settle_width_lp-1:0] settle_last_lp = settle_width_lp'(settle_cycles_p - 1);

    bsg_clk_gen_calib_meas_state_e state_r;
    logic [settle_width_lp-1:0]    settle_cnt_r;
    logic [window_width_p-1:0]     win_cnt_r;
    logic [count_width_p-1:0]      first_r;
    logic                          first_v_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_meas_idle;
            div_clear_o  <= 1'b0;
            div_enable_o <= 1'b0;
            done_o       <= 1'b0;
            sample_o     <= '0;
            settle_cnt_r <= '0;
            win_cnt_r    <= '0;
            first_r      <= '0;
            first_v_r    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                e_meas_idle: begin
                    if (start_i) begin
                        div_clear_o  <= 1'b1;
                        settle_cnt_r <= '0;
                        state_r      <= e_meas_clear;
                    end
                end
                e_meas_clear: begin
                    if (settle_cnt_r == settle_last_lp) begin
                        div_clear_o  <= 1'b0;
                        div_enable_o <= 1'b1;
                        win_cnt_r    <= '0;
                        state_r      <= e_meas_count;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                e_meas_count: begin
                    if (win_cnt_r == window_i - window_width_p'(1)) begin
                        div_enable_o <= 1'b0;
                        settle_cnt_r <= '0;
                        state_r      <= e_meas_hold;
                    end else begin
                        win_cnt_r <= win_cnt_r + 1'b1;
                    end
                end
                e_meas_hold: begin
                    if (settle_cnt_r == settle_last_lp) begin
                        first_v_r <= 1'b0;
                        state_r   <= e_meas_sample;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                e_meas_sample: begin
                    // Cross-domain value: accept only after two matching captures.
                    if (!first_v_r) begin
                        first_r   <= div_count_i;
                        first_v_r <= 1'b1;
                    end else if (div_count_i == first_r) begin
                        sample_o <= first_r;
                        done_o   <= 1'b1;
                        state_r  <= e_meas_idle;
                    end else begin
                        first_r <= div_count_i;
                    end
                end
                default: state_r <= e_meas_idle;
            endcase
        end
    end

endmodule

// File: rtl/bsg_clk_gen_calib_ctrl.sv
// Successive-approximation calibration of the oscillator control code,
// driving the monitor mux/divider controls and the measurement pass.
module bsg_clk_gen_calib_ctrl
    import bsg_clk_gen_calib_pkg::*;
#(
    parameter int unsigned ctl_width_p     = 5,
    parameter int unsigned count_width_p   = default_count_width_lp,
    parameter int unsigned window_width_p  = default_window_width_lp,
    parameter int unsigned settle_cycles_p = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [count_width_p-1:0]  target_i,
    input  logic [count_width_p-1:0]  tolerance_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic [count_width_p-1:0]  div_count_i,
    output logic                      mon_sel_o,
    output logic                      mon_reset_o,
    output logic                      div_reset_o,
    output logic                      div_clear_o,
    output logic                      div_enable_o,
    output logic [ctl_width_p-1:0]    ctl_o,
    output logic                      ctl_v_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      locked_o,
    output logic [count_width_p-1:0]  count_o
);

    localparam int unsigned bit_width_lp    = (ctl_width_p > 1) ? $clog2(ctl_width_p) : 1;
    localparam int unsigned settle_width_lp = $clog2(settle_cycles_p + 1);
    localparam logic [settle_width_lp-1:0] settle_last_lp = settle_width_lp'(settle_cycles_p - 1);

    bsg_clk_gen_calib_state_e   state_r;
    logic [bit_width_lp-1:0]    bit_r;
    logic [ctl_width_p-1:0]     kept_r;
    logic [count_width_p-1:0]   target_r;
    logic [count_width_p-1:0]   tol_r;
    logic [window_width_p-1:0]  window_r;
    logic [settle_width_lp-1:0] settle_cnt_r;
    logic                       meas_start_r;

    logic                       meas_done;
    logic [count_width_p-1:0]   meas_sample;

    logic [ctl_width_p-1:0]     bit_mask;
    logic [ctl_width_p-1:0]     trial;
    logic [ctl_width_p-1:0]     kept_next;
    logic [ctl_width_p-1:0]     next_trial;
    logic [count_width_p:0]     abs_err;
    logic                       locked_next;

    always_comb begin
        bit_mask   = ctl_width_p'(1) << bit_r;
        trial      = kept_r | bit_mask;
        // Count still at/above target means the clock is too fast: keep the delay bit.
        kept_next  = (meas_sample >= target_r) ? trial : kept_r;
        next_trial = kept_next | (bit_mask >> 1);
        abs_err    = (meas_sample >= target_r)
                   ? ({1'b0, meas_sample} - {1'b0, target_r})
                   : ({1'b0, target_r} - {1'b0, meas_sample});
        locked_next = (abs_err <= {1'b0, tol_r});
    end

    bsg_clk_gen_calib_measure #(
        .count_width_p  (count_width_p),
        .window_width_p (window_width_p),
        .settle_cycles_p(settle_cycles_p)
    ) measure (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (meas_start_r),
        .window_i    (window_r),
        .div_count_i (div_count_i),
        .div_clear_o (div_clear_o),
        .div_enable_o(div_enable_o),
        .done_o      (meas_done),
        .sample_o    (meas_sample)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_calib_idle;
            mon_sel_o    <= 1'b0;
            mon_reset_o  <= 1'b1;
            div_reset_o  <= 1'b1;
            ctl_o        <= '0;
            ctl_v_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            locked_o     <= 1'b0;
            count_o      <= '0;
            bit_r        <= '0;
            kept_r       <= '0;
            target_r     <= '0;
            tol_r        <= '0;
            window_r     <= '0;
            settle_cnt_r <= '0;
            meas_start_r <= 1'b0;
        end else begin
            ctl_v_o      <= 1'b0;
            meas_start_r <= 1'b0;
            case (state_r)
                e_calib_idle, e_calib_done: begin
                    if (start_i) begin
                        target_r     <= target_i;
                        tol_r        <= tolerance_i;
                        window_r     <= (window_i == '0) ? window_width_p'(1) : window_i;
                        bit_r        <= bit_width_lp'(ctl_width_p - 1);
                        kept_r       <= '0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        locked_o     <= 1'b0;
                        mon_reset_o  <= 1'b1;
                        div_reset_o  <= 1'b1;
                        settle_cnt_r <= '0;
                        state_r      <= e_calib_mrst;
                    end
                end
                e_calib_mrst: begin
                    if (settle_cnt_r == settle_last_lp) begin
                        mon_reset_o  <= 1'b0;
                        div_reset_o  <= 1'b0;
                        ctl_o        <= trial;
                        ctl_v_o      <= 1'b1;
                        settle_cnt_r <= '0;
                        state_r      <= e_calib_apply;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                e_calib_apply: begin
                    if (settle_cnt_r == settle_last_lp) begin
                        meas_start_r <= 1'b1;
                        state_r      <= e_calib_measure;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                e_calib_measure: begin
                    if (meas_done) begin
                        count_o <= meas_sample;
                        state_r <= e_calib_decide;
                    end
                end
                e_calib_decide: begin
                    kept_r       <= kept_next;
                    settle_cnt_r <= '0;
                    ctl_v_o      <= 1'b1;
                    if (bit_r != '0) begin
                        bit_r   <= bit_r - bit_width_lp'(1);
                        ctl_o   <= next_trial;
                        state_r <= e_calib_apply;
                    end else begin
                        ctl_o   <= kept_next;
                        state_r <= e_calib_final;
                    end
                end
                e_calib_final: begin
                    if (settle_cnt_r == settle_last_lp) begin
                        meas_start_r <= 1'b1;
                        state_r      <= e_calib_final_measure;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                e_calib_final_measure: begin
                    if (meas_done) begin
                        count_o  <= meas_sample;
                        locked_o <= locked_next;
                        ctl_o    <= kept_r;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        state_r  <= e_calib_done;
                    end
                end
                default: state_r <= e_calib_idle;
            endcase
        end
    end

endmodule

// File: doc/bsg_clk_gen_calib_ctrl.md
Name: bsg_clk_gen_calib_ctrl

Overview:
- Sequencer that calibrates the oscillator control code. It drives the monitor and divider-counter controls and runs a successive-approximation search.
- Each step: apply a trial code, let the oscillator settle, open a fixed measurement window on the divided monitor clock, read the count, and keep or clear the trial bit.
- Sits beside the clock generator and replaces manual tag-driven tuning of osc ctl, mon sel/reset and div reset/enable/clear.
- Runs in the always-present tag/ext clock domain.

Parameters:
- ctl_width_p, 5, width of the oscillator control code.
- count_width_p, 16, width of the divided-clock counter value.
- window_width_p, 20, width of the measurement-window length input.
- settle_cycles_p, 64, clk_i cycles held in each settle/reset/clear phase. Must be at least 4 div_clk periods at the slowest oscillator setting.

Ports:
- clk_i  in  1  controller clock.
- reset_i  in  1  reset; synchronous, active-high.
- start_i  in  1  pulse; starts calibration. Sampled only in IDLE or DONE.
- target_i  in  count_width_p  desired div count per window. Latched at start.
- tolerance_i  in  count_width_p  allowed abs error for lock. Latched at start.
- window_i  in  window_width_p  window length in clk_i cycles. Latched at start; 0 is treated as 1.
- div_count_i  in  count_width_p  counter value from the div_clk domain.
- mon_sel_o  out  1  monitor mux select; 0 selects the generated clock.
- mon_reset_o  out  1  LFSR divider reset.
- div_reset_o  out  1  counter reset.
- div_clear_o  out  1  counter clear.
- div_enable_o  out  1  counter up-enable.
- ctl_o  out  ctl_width_p  oscillator control code.
- ctl_v_o  out  1  one-cycle pulse; ctl_o is new.
- busy_o  out  1  calibration in progress.
- done_o  out  1  high in DONE.
- locked_o  out  1  final |count − target| ≤ tolerance.
- count_o  out  count_width_p  last accepted sample.

Behaviour:
- Reset values:
  - state = IDLE.
  - mon_sel_o = 0; mon_reset_o = 1; div_reset_o = 1.
  - div_clear_o = 0; div_enable_o = 0.
  - ctl_o = 0; ctl_v_o = 0.
  - busy_o = 0; done_o = 0; locked_o = 0; count_o = 0.
- Reset applied mid-operation aborts the search on the next edge and loads the same reset values.
- Code sense: a larger ctl gives more delay, i.e. lower frequency.
- Search rule: for bit index b from ctl_width_p−1 down to 0:
  - trial = kept bits | (1<<b).
  - If sample ≥ target, keep bit b (still too fast). Otherwise clear it.
  - After b = 0, do one FINAL measurement using the kept code.
- States:
  - IDLE/DONE: on start_i, latch inputs, set b = MSB, set busy_o = 1, clear done_o and locked_o, go to MRST.
  - MRST: assert mon_reset_o and div_reset_o for settle_cycles_p cycles, then go to APPLY.
  - APPLY: drive ctl_o = trial, pulse ctl_v_o for 1 cycle, then wait settle_cycles_p cycles.
  - CLEAR: hold div_clear_o = 1 for settle_cycles_p cycles.
  - COUNT: hold div_enable_o = 1 for exactly window cycles.
  - HOLD: enable low for settle_cycles_p cycles, so the counter is quiescent.
  - SAMPLE: capture div_count_i on two consecutive cycles. Accept only if the two values are equal; otherwise re-capture. Stay here until accepted. The accepted value goes to count_o. div_count_i is asynchronous, but it is static at this point.
  - DECIDE: update the kept bits. If b > 0, decrement b and go to APPLY; if b = 0, go to FINAL.
  - FINAL: reapply the kept code, then run CLEAR → COUNT → HOLD → SAMPLE once.
  - After FINAL's sample: set locked_o, ctl_o = kept code, busy_o = 0, done_o = 1, go to DONE.
- Outputs in DONE: ctl_o, locked_o and count_o are held until the next start or reset.
- mon_reset_o and div_reset_o are deasserted in every state except MRST and the reset state.
- Abs-error arithmetic is done at count_width_p+1 bits; no wrap.
- Counter saturation/overflow is the measurement owner's concern. An overflowed (wrapped) count is used as-is.
- start_i is ignored while busy_o = 1.

Decomposition:
- Package bsg_clk_gen_calib_pkg holds:
  - the state enum bsg_clk_gen_calib_state_e;
  - the default count and window widths.
- One natural sub-module: bsg_clk_gen_calib_measure. It owns CLEAR/COUNT/HOLD/SAMPLE and the settle counter, with a start/done handshake and a sample output. The top-level FSM owns the SAR bits and lock decision.

Test Plan:
- Reset mid-COUNT, then release → next cycle all outputs equal their reset values; no ctl_v_o pulse.
- Model: count = 2000 − 50·ctl, target = 1500, tolerance = 25, ctl_width_p = 5 → ctl_o = 10, count_o = 1500, locked_o = 1, exactly 6 ctl_v_o pulses.
- Same model with target = 4000 (unreachable) → ctl_o = 0, locked_o = 0, done_o = 1.
- Target = 0 → all bits kept, ctl_o = 31, locked_o = 1 when model count at code 31 is within tolerance.
- div_count_i toggles on the first sample cycle → SAMPLE re-captures, and the accepted value equals the stable value.
- start_i pulsed while busy → ignored; window_i = 0 → div_enable_o high for exactly 1 cycle per measurement.
